// File: rtl/vx_line_ser_pkg.sv
// Shared types and default geometry for the Vortex line-to-word serializer.
package vx_line_ser_pkg;

    localparam int LINE_BYTES_DEF = 64;
    localparam int WORDS_PER_LINE = LINE_BYTES_DEF / 4;
    localparam int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/vx_line_word_buffer.sv
// Word-addressed register array used to reassemble read beats into a full line.
module vx_line_word_buffer
    import vx_line_ser_pkg::*;
#(
    parameter int WORDS = WORDS_PER_LINE,
    parameter int IDX_W = BEAT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    output logic [WORDS*32-1:0]   line
);

    logic [WORDS-1:0][31:0] mem_q;
    logic [WORDS-1:0][31:0] mem_d;

    // Next contents: replace only the indexed word
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign line = mem_q;

endmodule

// File: rtl/vx_mem_line_serializer.sv
// Serialises 512-bit Vortex line requests into 32-bit generic-bus word transfers.
// Optional VX_LINE_SER_SKIP_EN: write beats with an all-zero byte-enable nibble are skipped.
module vx_mem_line_serializer
    import vx_line_ser_pkg::*;
#(
    parameter int          LINE_BYTES     = LINE_BYTES_DEF,
    parameter int          MEM_ADDR_WIDTH = 26,
    parameter int          TAG_WIDTH      = 56,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_req_valid,
    input  logic                      mem_req_rw,
    input  logic [LINE_BYTES-1:0]     mem_req_byteen,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic [LINE_BYTES*8-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]      mem_req_tag,
    output logic                      mem_req_ready,
    output logic                      mem_rsp_valid,
    output logic [LINE_BYTES*8-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]      mem_rsp_tag,
    input  logic                      mem_rsp_ready,
    output logic [31:0]               bus_addr,
    output logic [31:0]               bus_wdata,
    input  logic [31:0]               bus_rdata,
    output logic                      bus_ren,
    output logic                      bus_wen,
    output logic [3:0]                bus_byte_en,
    input  logic                      bus_busy,
    output logic                      busy
);

    localparam int               NWORDS    = LINE_BYTES / 4;
    localparam int               CNT_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NWORDS - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          beat_q, beat_d;
    logic                      rw_q, rw_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_BYTES*8-1:0]   data_q, data_d;
    logic [LINE_BYTES-1:0]     byteen_q, byteen_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;

    logic [31:0]                     word_s;
    logic [3:0]                      nibble_s;
    logic [MEM_ADDR_WIDTH+CNT_W+1:0] offset_s;
    logic                            skip_s;
    logic                            done_s;
    logic                            buf_wr_s;

    // Current beat's write word, enable nibble and byte offset of the word
    always_comb begin
        word_s   = data_q[{beat_q, 5'd0} +: 32];
        nibble_s = byteen_q[{beat_q, 2'd0} +: 4];
        offset_s = {addr_q, beat_q, 2'b00};
    end

`ifdef VX_LINE_SER_SKIP_EN
    assign skip_s = rw_q && (nibble_s == 4'h0);
`else
    assign skip_s = 1'b0;
`endif

    assign done_s   = (state_q == BEAT) && (skip_s || !bus_busy);
    assign buf_wr_s = (state_q == BEAT) && !rw_q && !bus_busy;

    // Output decode: driven only by registered state, never by request/response inputs
    always_comb begin
        mem_req_ready = (state_q == IDLE);
        mem_rsp_valid = (state_q == RESP);
        busy          = (state_q != IDLE);
        bus_ren       = 1'b0;
        bus_wen       = 1'b0;
        bus_addr      = 32'h0000_0000;
        bus_wdata     = 32'h0000_0000;
        bus_byte_en   = 4'h0;
        if ((state_q == BEAT) && !skip_s) begin
            bus_addr = BASE_ADDR + 32'(offset_s);
            if (rw_q) begin
                bus_wen     = 1'b1;
                bus_wdata   = word_s;
                bus_byte_en = nibble_s;
            end else begin
                bus_ren     = 1'b1;
                bus_byte_en = 4'hF;
            end
        end else begin
            bus_addr = 32'h0000_0000;
        end
    end

    // Next-state: accept in IDLE, step beats on completion, hold response until consumed
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        data_d   = data_q;
        byteen_d = byteen_q;
        tag_d    = tag_q;
        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    rw_d     = mem_req_rw;
                    addr_d   = mem_req_addr;
                    data_d   = mem_req_data;
                    byteen_d = mem_req_byteen;
                    tag_d    = mem_req_tag;
                    beat_d   = '0;
                    state_d  = BEAT;
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT: begin
                if (done_s && (beat_q == LAST_BEAT)) begin
                    state_d = rw_q ? IDLE : RESP;
                end else if (done_s) begin
                    beat_d = beat_q + CNT_W'(1);
                end else begin
                    state_d = BEAT;
                end
            end
            RESP: begin
                if (mem_rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request-latch registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            byteen_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            byteen_q <= byteen_d;
            tag_q    <= tag_d;
        end
    end

    vx_line_word_buffer #(
        .WORDS (NWORDS),
        .IDX_W (CNT_W)
    ) u_rd_buf (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (buf_wr_s),
        .wr_idx  (beat_q),
        .wr_data (bus_rdata),
        .line    (mem_rsp_data)
    );

    assign mem_rsp_tag = tag_q;

endmodule

// File: tb/tb_vx_mem_line_serializer.sv
// Directed scoreboard bench for vx_mem_line_serializer with a generic-bus RAM model.
module tb_vx_mem_line_serializer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wen;
    } xfer_t;

    typedef struct {
        logic [511:0] data;
        logic [55:0]  tag;
    } rsp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mem_req_valid = 1'b0;
    logic         mem_req_rw = 1'b0;
    logic [63:0]  mem_req_byteen = 64'h0;
    logic [25:0]  mem_req_addr = 26'h0;
    logic [511:0] mem_req_data = 512'h0;
    logic [55:0]  mem_req_tag = 56'h0;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_data;
    logic [55:0]  mem_rsp_tag;
    logic         mem_rsp_ready = 1'b1;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ren;
    logic         bus_wen;
    logic [3:0]   bus_byte_en;
    logic         bus_busy = 1'b0;
    logic         busy;

    // second instance with a wrapping base address
    logic         w_req_valid = 1'b0;
    logic [25:0]  w_req_addr = 26'h0;
    logic [55:0]  w_req_tag = 56'h0;
    logic         w_req_ready;
    logic         w_rsp_valid;
    logic [511:0] w_rsp_data;
    logic [55:0]  w_rsp_tag;
    logic [31:0]  w_bus_addr;
    logic [31:0]  w_bus_wdata;
    logic [31:0]  w_bus_rdata;
    logic         w_bus_ren;
    logic         w_bus_wen;
    logic [3:0]   w_bus_byte_en;
    logic         w_busy;

    int compared = 0;
    int mismatched = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    int xfer_cnt = 0;
    logic stalled_prev = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_ren, h_wen;
    logic        rsp_prev_stall = 1'b0;
    logic [511:0] h_rsp_data;
    logic [55:0]  h_rsp_tag;

    logic [31:0] ram [0:255];
    xfer_t exp_xfer_q[$];
    rsp_t  exp_rsp_q[$];

    vx_mem_line_serializer dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ren(bus_ren),
        .bus_wen(bus_wen), .bus_byte_en(bus_byte_en), .bus_busy(bus_busy), .busy(busy)
    );

    vx_mem_line_serializer #(.BASE_ADDR(32'hFFFF_FFC0)) dut_wrap (
        .clk(clk), .reset(reset),
        .mem_req_valid(w_req_valid), .mem_req_rw(1'b0), .mem_req_byteen(64'h0),
        .mem_req_addr(w_req_addr), .mem_req_data(512'h0), .mem_req_tag(w_req_tag),
        .mem_req_ready(w_req_ready), .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
        .mem_rsp_tag(w_rsp_tag), .mem_rsp_ready(1'b1),
        .bus_addr(w_bus_addr), .bus_wdata(w_bus_wdata), .bus_rdata(w_bus_rdata), .bus_ren(w_bus_ren),
        .bus_wen(w_bus_wen), .bus_byte_en(w_bus_byte_en), .bus_busy(1'b0), .busy(w_busy)
    );

    always #5 clk = ~clk;

    assign bus_rdata   = ram[bus_addr[9:2]];
    assign w_bus_rdata = w_bus_addr ^ 32'h5A5A_5A5A;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus slave model: inserts stall cycles, checks hold-while-busy, scores completed transfers
    always @(negedge clk) begin
        if (!reset) begin
            bus_busy = 1'b0;
            stall_cnt = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("hold_addr", 512'(bus_addr), 512'(h_addr));
                chk("hold_ren", 512'(bus_ren), 512'(h_ren));
                chk("hold_wen", 512'(bus_wen), 512'(h_wen));
                chk("hold_be", 512'(bus_byte_en), 512'(h_be));
                chk("hold_wdata", 512'(bus_wdata), 512'(h_wdata));
            end
            if (bus_ren || bus_wen) begin
                chk("ren_wen_excl", 512'(bus_ren & bus_wen), 512'(0));
                if (stall_cnt < stall_n) begin
                    bus_busy = 1'b1;
                    stall_cnt++;
                    stalled_prev = 1'b1;
                    h_addr = bus_addr; h_ren = bus_ren; h_wen = bus_wen;
                    h_be = bus_byte_en; h_wdata = bus_wdata;
                end else begin
                    bus_busy = 1'b0;
                    stall_cnt = 0;
                    stalled_prev = 1'b0;
                    xfer_cnt++;
                    chk("xfer_expected", 512'(exp_xfer_q.size() != 0), 512'(1));
                    if (exp_xfer_q.size() != 0) begin
                        xfer_t e;
                        e = exp_xfer_q.pop_front();
                        chk("xfer_addr", 512'(bus_addr), 512'(e.addr));
                        chk("xfer_be", 512'(bus_byte_en), 512'(e.be));
                        chk("xfer_wen", 512'(bus_wen), 512'(e.wen));
                        if (e.wen) chk("xfer_wdata", 512'(bus_wdata), 512'(e.wdata));
                    end
                    if (bus_wen) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_byte_en[b]) ram[bus_addr[9:2]][8*b +: 8] = bus_wdata[8*b +: 8];
                    end
                end
            end else begin
                bus_busy = 1'b0;
                stall_cnt = 0;
                stalled_prev = 1'b0;
            end
        end
    end

    // Response monitor: hold-while-stalled and scoreboard compare at handshake
    always @(negedge clk) begin
        if (!reset) begin
            rsp_prev_stall = 1'b0;
        end else begin
            if (rsp_prev_stall) begin
                chk("rsp_valid_hold", 512'(mem_rsp_valid), 512'(1));
                chk("rsp_data_hold", mem_rsp_data, h_rsp_data);
                chk("rsp_tag_hold", 512'(mem_rsp_tag), 512'(h_rsp_tag));
            end
            rsp_prev_stall = mem_rsp_valid && !mem_rsp_ready;
            h_rsp_data = mem_rsp_data;
            h_rsp_tag = mem_rsp_tag;
            if (mem_rsp_valid && mem_rsp_ready) begin
                chk("rsp_expected", 512'(exp_rsp_q.size() != 0), 512'(1));
                if (exp_rsp_q.size() != 0) begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_data", mem_rsp_data, r.data);
                    chk("rsp_tag", 512'(mem_rsp_tag), 512'(r.tag));
                end
            end
        end
    end

    task automatic exp_read(input logic [25:0] la, input logic [511:0] d, input logic [55:0] t);
        xfer_t x;
        rsp_t r;
        for (int i = 0; i < 16; i++) begin
            x.addr = {la, 6'd0} + 32'(i * 4);
            x.wdata = 32'h0; x.be = 4'hF; x.wen = 1'b0;
            exp_xfer_q.push_back(x);
        end
        r.data = d; r.tag = t;
        exp_rsp_q.push_back(r);
    endtask

    task automatic exp_write(input logic [25:0] la, input logic [511:0] d, input logic [63:0] be, output int n);
        xfer_t x;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            x.addr = {la, 6'd0} + 32'(i * 4);
            x.wdata = d[32*i +: 32]; x.be = be[4*i +: 4]; x.wen = 1'b1;
`ifdef VX_LINE_SER_SKIP_EN
            if (x.be != 4'h0) begin exp_xfer_q.push_back(x); n++; end
`else
            exp_xfer_q.push_back(x); n++;
`endif
        end
    endtask

    task automatic send_req(input logic rw, input logic [25:0] a, input logic [511:0] d,
                            input logic [63:0] be, input logic [55:0] t);
        int n = 0;
        while (!mem_req_ready && n < 300) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", 512'(mem_req_ready), 512'(1));
        mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = a;
        mem_req_data = d; mem_req_byteen = be; mem_req_tag = t;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin @(posedge clk); #1; n++; end
        chk(tag, 512'(busy), 512'(0));
    endtask

    initial begin
        logic [511:0] line;
        int n, nx, x0;
        logic [31:0] w, m;

        for (int k = 0; k < 256; k++) ram[k] = 32'h5555_0000 + 32'(k);
        for (int i = 0; i < 16; i++) ram[16 + i] = 32'hA000_0000 + 32'(i);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 512'(mem_req_ready), 512'(1));
        chk("rst_rsp_valid", 512'(mem_rsp_valid), 512'(0));
        chk("rst_strobes", 512'({bus_ren, bus_wen, busy}), 512'(0));
        chk("rst_bus_out", 512'({bus_addr, bus_wdata, bus_byte_en}), 512'(0));
        chk("rst_rsp_out", 512'({mem_rsp_data, mem_rsp_tag}), 512'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: zero-wait read of line 1
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'hA000_0000 + 32'(i);
        exp_read(26'h1, line, 56'h12_3456_789A_BCDE);
        send_req(1'b0, 26'h1, 512'h0, 64'h0, 56'h12_3456_789A_BCDE);
        n = 0;
        while (!mem_rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("t1_rd_latency", 512'(n), 512'(16));
        wait_idle("t1_idle");
        chk("t1_drained", 512'(exp_xfer_q.size() + exp_rsp_q.size()), 512'(0));

        // 2: full-line write to line 2, then read it back
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'(i);
        exp_write(26'h2, line, {64{1'b1}}, nx);
        send_req(1'b1, 26'h2, line, {64{1'b1}}, 56'h2);
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("t2_wr_latency", 512'(n), 512'(16));
        chk("t2_drained", 512'(exp_xfer_q.size()), 512'(0));
        exp_read(26'h2, line, 56'hAA);
        send_req(1'b0, 26'h2, 512'h0, 64'h0, 56'hAA);
        wait_idle("t2_rb_idle");
        chk("t2_rb_drained", 512'(exp_xfer_q.size() + exp_rsp_q.size()), 512'(0));

        // 3: sparse write, only word 3 bytes 1..2 enabled
        line = {16{32'hFFFF_FFFF}};
        line[32*3 +: 32] = 32'hDEAD_BEEF;
        x0 = xfer_cnt;
        exp_write(26'h3, line, 64'h0000_0000_0000_6000, nx);
        send_req(1'b1, 26'h3, line, 64'h0000_0000_0000_6000, 56'h3);
        wait_idle("t3_idle");
`ifdef VX_LINE_SER_SKIP_EN
        chk("t3_xfer_count", 512'(xfer_cnt - x0), 512'(1));
`else
        chk("t3_xfer_count", 512'(xfer_cnt - x0), 512'(16));
`endif
        chk("t3_expected_count", 512'(xfer_cnt - x0), 512'(nx));
        m = 32'h00FF_FF00;
        for (int i = 0; i < 16; i++) begin
            w = 32'h5555_0000 + 32'(48 + i);
            if (i == 3) w = (w & ~m) | (32'hDEAD_BEEF & m);
            line[32*i +: 32] = w;
        end
        exp_read(26'h3, line, 56'h33);
        send_req(1'b0, 26'h3, 512'h0, 64'h0, 56'h33);
        wait_idle("t3_rb_idle");

        // 4: stalled bus and stalled response consumer
        stall_n = 3;
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'h5555_0000 + 32'(80 + i);
        exp_read(26'h5, line, 56'hFE_DCBA_9876_5432);
        send_req(1'b0, 26'h5, 512'h0, 64'h0, 56'hFE_DCBA_9876_5432);
        n = 0;
        while (!mem_rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
        chk("t4_rsp_arrives", 512'(mem_rsp_valid), 512'(1));
        for (int k = 0; k < 5; k++) begin
            chk("t4_req_ready_low", 512'(mem_req_ready), 512'(0));
            @(posedge clk); #1;
        end
        mem_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_req_ready_after", 512'(mem_req_ready), 512'(1));
        chk("t4_drained", 512'(exp_xfer_q.size() + exp_rsp_q.size()), 512'(0));
        stall_n = 0;

        // 5: reset during beat 7 of a read
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'h5555_0000 + 32'(64 + i);
        exp_read(26'h4, line, 56'h55);
        x0 = xfer_cnt;
        send_req(1'b0, 26'h4, 512'h0, 64'h0, 56'h55);
        n = 0;
        while ((xfer_cnt - x0) < 7 && n < 100) begin @(posedge clk); #1; n++; end
        #1;
        chk("t5_beat7_ren", 512'(bus_ren), 512'(1));
        chk("t5_beat7_addr", 512'(bus_addr), 512'(32'h0000_011C));
        reset = 1'b0;
        #1;
        chk("t5_rst_ren", 512'(bus_ren), 512'(0));
        chk("t5_rst_busy", 512'(busy), 512'(0));
        chk("t5_rst_addr", 512'(bus_addr), 512'(0));
        exp_xfer_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_req_ready", 512'(mem_req_ready), 512'(1));
        for (int i = 0; i < 16; i++) line[32*i +: 32] = 32'hA000_0000 + 32'(i);
        exp_read(26'h1, line, 56'h77);
        send_req(1'b0, 26'h1, 512'h0, 64'h0, 56'h77);
        wait_idle("t5_idle");
        chk("t5_drained", 512'(exp_xfer_q.size() + exp_rsp_q.size()), 512'(0));

        // 6: base address wraps modulo 2^32
        w_req_valid = 1'b1; w_req_addr = 26'h1; w_req_tag = 56'h66;
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t6_ren", 512'({w_bus_ren, w_bus_wen, w_bus_byte_en, w_bus_wdata}), 512'({2'b10, 4'hF, 32'h0}));
            chk("t6_addr", 512'(w_bus_addr), 512'(32'(i * 4)));
            line[32*i +: 32] = 32'(i * 4) ^ 32'h5A5A_5A5A;
            @(posedge clk); #1;
        end
        chk("t6_rsp_valid", 512'(w_rsp_valid), 512'(1));
        chk("t6_rsp_data", w_rsp_data, line);
        chk("t6_rsp_tag", 512'(w_rsp_tag), 512'(56'h66));
        @(posedge clk); #1;
        chk("t6_idle", 512'({w_busy, w_req_ready}), 512'({1'b0, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no completion, expected finish before 300000");
        $fatal(1, "watchdog");
    end

endmodule
